uart_rx_oversampled: RTL and testbench

- UART receiver, 8N1 by default, LSB first.
- Consumes the single-cycle oversampling tick produced by the divider block and recovers bytes from the asynchronous rx line.
- Sits between an external UART pin and the mux fabric.
- Delivers each byte with a one-cycle valid pulse; a bad stop bit raises a framing-error pulse instead.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/sync_ff.sv | 31 +++
 rtl/uart_rx_oversampled.sv | 153 +++++++++++++++
 tb/tb_uart_rx_oversampled.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receiver state encoding
//
// Purpose : state encoding and default frame parameters shared by the UART
//           receiver and the future transmitter.
// Ports   : none (package).
package uart_pkg;

    localparam int UART_STATE_W       = 3;
    localparam int DEFAULT_OVERSAMPLE = 16;
    localparam int DEFAULT_DATA_BITS  = 8;

    typedef enum logic [UART_STATE_W-1:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_t;

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - multi-stage single-bit synchronizer with selectable reset value
//
// Purpose : brings an asynchronous level into the clk domain through STAGES flops.
// Ports   : clk     - system clock
//           reset   - synchronous, active-high reset; loads every stage with rst_val
//           rst_val - value all stages take during reset
//           d       - asynchronous input
//           q       - synchronized output (last stage)
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic rst_val,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr <= {STAGES{rst_val}};
        end else begin
            sr <= {sr[STAGES-2:0], d};
        end
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/uart_rx_oversampled.sv
// rtl/uart_rx_oversampled.sv - oversampled UART receiver, LSB first, one stop bit
//
// Purpose : recovers words from an asynchronous rx line using an external
//           oversampling tick (OVERSAMPLE ticks per bit).
// Ports   : clk           - system clock
//           reset         - synchronous, active-high reset
//           tick          - one-clk oversampling pulse
//           rx            - asynchronous serial input, idle high
//           data_out      - last correctly received word
//           data_valid    - one-clk pulse when data_out is updated
//           framing_error - one-clk pulse when the stop bit samples low
//           busy          - high whenever the receiver is not idle
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = DEFAULT_DATA_BITS,
    parameter int OVERSAMPLE  = DEFAULT_OVERSAMPLE,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 framing_error,
    output logic                 busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    logic rx_s;

    // Line idles high, so the synchronizer resets to 1 to avoid a false start.
    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset   (reset),
        .rst_val (1'b1),
        .d       (rx),
        .q       (rx_s)
    );

    uart_state_t          state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [BIT_W-1:0]     bit_idx, bit_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic [DATA_BITS-1:0] data_n;
    logic                 valid_n, ferr_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            shift         <= '0;
            data_out      <= '0;
            data_valid    <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            bit_idx       <= bit_n;
            shift         <= shift_n;
            data_out      <= data_n;
            data_valid    <= valid_n;
            framing_error <= ferr_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_idx;
        shift_n = shift;
        data_n  = data_out;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
        if (tick) begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state_n = START;
                        cnt_n   = '0;
                    end
                end
                START: begin
                    // Re-check at the start-bit midpoint to reject glitches.
                    if (cnt == CNT_MID) begin
                        if (!rx_s) begin
                            state_n = DATA;
                            cnt_n   = '0;
                            bit_n   = '0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        cnt_n = cnt + CNT_ONE;
                    end
                end
                DATA: begin
                    // Counter restarted at the start midpoint, so every full
                    // period lands on a data-bit midpoint.
                    if (cnt == CNT_LAST) begin
                        shift_n = {rx_s, shift[DATA_BITS-1:1]};
                        cnt_n   = '0;
                        bit_n   = bit_idx + BIT_ONE;
                        if (bit_idx == BIT_LAST) begin
                            state_n = STOP;
                        end
                    end else begin
                        cnt_n = cnt + CNT_ONE;
                    end
                end
                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt_n = '0;
                        if (rx_s) begin
                            data_n  = shift;
                            valid_n = 1'b1;
                            state_n = IDLE;
                        end else begin
                            ferr_n  = 1'b1;
                            state_n = BREAK;
                        end
                    end else begin
                        cnt_n = cnt + CNT_ONE;
                    end
                end
                BREAK: begin
                    // A held-low line must go high before a new start is seen.
                    if (rx_s) begin
                        state_n = IDLE;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb/tb_uart_rx_oversampled.sv - directed scoreboard bench for uart_rx_oversampled
module tb_uart_rx_oversampled;

    localparam int CLKS_PER_TICK = 4;
    localparam int OS            = 16;
    localparam int BIT_CLKS      = OS * CLKS_PER_TICK;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       rx = 1'b1;
    logic       tick_en = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       framing_error;
    logic       busy;

    int tests = 0;
    int fails = 0;
    int vcount = 0;
    int fcount = 0;
    int tdiv = 0;
    logic [7:0] exp_q[$];

    uart_rx_oversampled #(
        .DATA_BITS   (8),
        .OVERSAMPLE  (OS),
        .SYNC_STAGES (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .tick          (tick),
        .rx            (rx),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .framing_error (framing_error),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Tick every CLKS_PER_TICK clks; the phase freezes while tick_en is low.
    always @(negedge clk) begin
        if (tick_en) begin
            tdiv = (tdiv == CLKS_PER_TICK - 1) ? 0 : tdiv + 1;
            tick = (tdiv == 0);
        end else begin
            tick = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every data_valid pops the oldest expected word.
    always @(negedge clk) begin
        if (data_valid) begin
            vcount++;
            check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check("data_out", 32'(data_out), 32'(exp_q.pop_front()));
            end
            check("valid_ferr_excl", 32'(framing_error), 32'd0);
        end
        if (framing_error) begin
            fcount++;
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int stall_bit);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        if (stop_bit) begin
            exp_q.push_back(b);
        end
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            if (i == stall_bit) begin
                wait_clks(BIT_CLKS / 2);
                tick_en = 1'b0;
                for (int k = 0; k < 100; k++) begin
                    @(negedge clk);
                    check("stall_busy", 32'(busy), 32'd1);
                    check("stall_no_pulse", 32'(data_valid | framing_error), 32'd0);
                end
                tick_en = 1'b1;
                wait_clks(BIT_CLKS / 2);
            end else begin
                wait_clks(BIT_CLKS);
            end
        end
        rx = 1'b1;
    endtask

    int v0, f0;

    initial begin
        wait_clks(3);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_ferr", 32'(framing_error), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        tick_en = 1'b1;
        wait_clks(BIT_CLKS);

        // Single 0x55 frame.
        v0 = vcount; f0 = fcount;
        send_frame(8'h55, 1'b1, -1);
        wait_clks(8);
        check("f55_valid_cnt", 32'(vcount - v0), 32'd1);
        check("f55_ferr_cnt", 32'(fcount - f0), 32'd0);
        check("f55_busy", 32'(busy), 32'd0);

        // Back-to-back frames with no idle gap.
        v0 = vcount;
        send_frame(8'hA5, 1'b1, -1);
        send_frame(8'h3C, 1'b1, -1);
        wait_clks(8);
        check("b2b_valid_cnt", 32'(vcount - v0), 32'd2);
        check("b2b_last", 32'(data_out), 32'h3C);

        // Start-bit glitch of three ticks.
        v0 = vcount; f0 = fcount;
        wait_clks(BIT_CLKS);
        rx = 1'b0;
        wait_clks(3 * CLKS_PER_TICK);
        rx = 1'b1;
        wait_clks(20 * CLKS_PER_TICK);
        check("glitch_busy", 32'(busy), 32'd0);
        check("glitch_valid", 32'(vcount - v0), 32'd0);
        check("glitch_ferr", 32'(fcount - f0), 32'd0);
        check("glitch_data", 32'(data_out), 32'h3C);

        // Framing error followed by a held-low line.
        send_frame(8'h55, 1'b1, -1);
        wait_clks(BIT_CLKS);
        v0 = vcount; f0 = fcount;
        send_frame(8'h3C, 1'b0, 9);
        rx = 1'b0;
        wait_clks(40 * CLKS_PER_TICK - BIT_CLKS);
        check("fe_ferr_cnt", 32'(fcount - f0), 32'd1);
        check("fe_valid_cnt", 32'(vcount - v0), 32'd0);
        check("fe_data_kept", 32'(data_out), 32'h55);
        check("fe_break_busy", 32'(busy), 32'd1);
        rx = 1'b1;
        wait_clks(BIT_CLKS);
        check("fe_idle", 32'(busy), 32'd0);
        check("fe_single", 32'(fcount - f0), 32'd1);
        v0 = vcount;
        send_frame(8'h81, 1'b1, -1);
        wait_clks(8);
        check("f81_valid_cnt", 32'(vcount - v0), 32'd1);

        // Reset during data bit 4 of 0xFF.
        wait_clks(BIT_CLKS);
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        rx = 1'b1;
        wait_clks(4 * BIT_CLKS + BIT_CLKS / 2);
        check("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        wait_clks(1);
        check("mid_rst_data", 32'(data_out), 32'd0);
        check("mid_rst_valid", 32'(data_valid), 32'd0);
        check("mid_rst_ferr", 32'(framing_error), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        wait_clks(5 * BIT_CLKS);
        v0 = vcount;
        send_frame(8'h12, 1'b1, -1);
        wait_clks(8);
        check("f12_valid_cnt", 32'(vcount - v0), 32'd1);
        check("f12_data", 32'(data_out), 32'h12);

        // Tick stall in the middle of data bit 3.
        wait_clks(BIT_CLKS);
        v0 = vcount; f0 = fcount;
        send_frame(8'h5A, 1'b1, 4);
        wait_clks(8);
        check("stall_valid_cnt", 32'(vcount - v0), 32'd1);
        check("stall_ferr_cnt", 32'(fcount - f0), 32'd0);
        check("stall_data", 32'(data_out), 32'h5A);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
